// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: machine word, fetch FSM
// encoding and the sequential-PC helper.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t INSTR_BYTES = 32'd4;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 gives 0.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the icache, the next-PC block and decode.
// The fe modport is the fetch stage; tb is the environment around it.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  // Icache handshake: imemREN is the request and imemaddr the address.
  // ihit acts as valid: when it is 1, imemload holds the word for the
  // imemaddr of that same cycle. There is no ready; the cache cannot
  // cancel a request that is already in flight.
  word_t        next_PC;
  logic         redirect;
  logic         stall;
  logic         halt;
  logic         ihit;
  word_t        imemload;
  logic         imemREN;
  word_t        imemaddr;
  word_t        PC4;
  word_t        ifid_instr;
  word_t        ifid_pc4;
  logic         ifid_valid;
  fetch_state_t state;

  modport fe (
    input  next_PC, redirect, stall, halt, ihit, imemload,
    output imemREN, imemaddr, PC4, ifid_instr, ifid_pc4, ifid_valid, state
  );

  modport tb (
    output next_PC, redirect, stall, halt, ihit, imemload,
    input  imemREN, imemaddr, PC4, ifid_instr, ifid_pc4, ifid_valid, state
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request and writes
// the IF/ID latch. It can drain a miss abandoned by a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC0 = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       nRST,
  fetch_stage_if.fe  fif
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        pend_addr, pend_addr_n;
  word_t        ifid_instr_q, ifid_instr_n;
  word_t        ifid_pc4_q, ifid_pc4_n;
  logic         ifid_valid_q, ifid_valid_n;
  word_t        pc4;

  assign pc4 = pc_plus4(pc);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= FETCH;
      pc           <= PC0;
      pend_addr    <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pend_addr    <= pend_addr_n;
      ifid_instr_q <= ifid_instr_n;
      ifid_pc4_q   <= ifid_pc4_n;
      ifid_valid_q <= ifid_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_addr_n  = pend_addr;
    ifid_instr_n = ifid_instr_q;
    ifid_pc4_n   = ifid_pc4_q;
    ifid_valid_n = ifid_valid_q;

    unique case (state)
      FETCH: begin
        if (fif.halt) begin
          state_n      = HALTED;
          ifid_valid_n = 1'b0;
        end else if (fif.redirect) begin
          // A hit this cycle is wrong-path and dropped. A miss is still in
          // flight, so remember its address and wait for it to come back.
          pc_n         = fif.next_PC;
          ifid_valid_n = 1'b0;
          if (!fif.ihit) begin
            pend_addr_n = pc;
            state_n     = DRAIN;
          end
        end else if (fif.stall) begin
          // Hold everything; a hit returned now is fetched again next cycle.
        end else if (fif.ihit) begin
          ifid_instr_n = fif.imemload;
          ifid_pc4_n   = pc4;
          ifid_valid_n = 1'b1;
          pc_n         = fif.next_PC;
        end else begin
          ifid_valid_n = 1'b0;
        end
      end

      DRAIN: begin
        ifid_valid_n = 1'b0;
        if (fif.halt) begin
          state_n = HALTED;
        end else begin
          // Later redirects overwrite the target; the word returned for
          // pend_addr is always thrown away.
          if (fif.redirect) pc_n = fif.next_PC;
          if (fif.ihit) state_n = FETCH;
        end
      end

      HALTED: begin
        ifid_valid_n = 1'b0;
      end

      default: begin
        state_n      = FETCH;
        ifid_valid_n = 1'b0;
      end
    endcase
  end

  always_comb begin
    fif.PC4        = pc4;
    fif.imemREN    = nRST && (state != HALTED);
    fif.imemaddr   = (state == DRAIN) ? pend_addr : pc;
    fif.ifid_instr = ifid_instr_q;
    fif.ifid_pc4   = ifid_pc4_q;
    fif.ifid_valid = ifid_valid_q;
    fif.state      = state;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random traffic, all
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t PC0 = 32'h0000_0100;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_stage_if fif ();

  fetch_stage #(.PC0(PC0)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (fif)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: a PC, a "waiting for an abandoned miss" flag with its
  // address, a halted flag and the IF/ID contents.
  word_t m_pc, m_pend, m_instr, m_ipc4;
  logic  m_drain, m_halt, m_valid;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_pc = PC0; m_pend = 0; m_drain = 0; m_halt = 0;
      m_instr = 0; m_ipc4 = 0; m_valid = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (m_drain) begin
      m_valid = 0;
      if (fif.halt) begin
        m_halt = 1; m_drain = 0;
      end else begin
        if (fif.redirect) m_pc = fif.next_PC;
        if (fif.ihit) m_drain = 0;
      end
    end else if (fif.halt) begin
      m_halt = 1; m_valid = 0;
    end else if (fif.redirect) begin
      if (!fif.ihit) begin
        m_pend = m_pc; m_drain = 1;
      end
      m_pc = fif.next_PC; m_valid = 0;
    end else if (fif.stall) begin
      m_valid = m_valid;
    end else if (fif.ihit) begin
      m_instr = fif.imemload; m_ipc4 = m_pc + 32'd4;
      m_valid = 1; m_pc = fif.next_PC;
    end else begin
      m_valid = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_state;
    exp_state = m_halt ? {30'b0, HALTED} : (m_drain ? {30'b0, DRAIN} : {30'b0, FETCH});
    check("imemREN",    {31'b0, fif.imemREN}, {31'b0, nRST && !m_halt});
    check("imemaddr",   fif.imemaddr, m_drain ? m_pend : m_pc);
    check("PC4",        fif.PC4, m_pc + 32'd4);
    check("ifid_valid", {31'b0, fif.ifid_valid}, {31'b0, m_valid});
    check("ifid_instr", fif.ifid_instr, m_instr);
    check("ifid_pc4",   fif.ifid_pc4, m_ipc4);
    check("state",      {30'b0, fif.state}, exp_state);
  endtask

  // Apply one cycle of inputs away from the rising edge, then compare the
  // DUT against the model state produced by the previous edge.
  task automatic drive(input logic rst_n, input word_t npc, input logic rd,
                       input logic st, input logic hl, input logic hit,
                       input word_t load);
    @(negedge CLK);
    nRST = rst_n; fif.next_PC = npc; fif.redirect = rd; fif.stall = st;
    fif.halt = hl; fif.ihit = hit; fif.imemload = load;
    #1;
    check_model();
  endtask

  initial begin
    word_t npc, held;
    logic  rst_n, rd, st, hl, hit;

    nRST = 0; fif.next_PC = 0; fif.redirect = 0; fif.stall = 0;
    fif.halt = 0; fif.ihit = 0; fif.imemload = 0;
    @(posedge CLK);

    // Reset held for two cycles, then released.
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_ren_low", {31'b0, fif.imemREN}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_ren_low2", {31'b0, fif.imemREN}, 32'd0);
    drive(1, 32'h104, 0, 0, 0, 1, 32'hAAAA_0001);
    check("rst_addr",  fif.imemaddr, 32'h100);
    check("rst_pc4",   fif.PC4, 32'h104);
    check("rst_valid", {31'b0, fif.ifid_valid}, 32'd0);
    check("rst_ren",   {31'b0, fif.imemREN}, 32'd1);

    // Back-to-back hits A, B, C.
    drive(1, 32'h108, 0, 0, 0, 1, 32'hBBBB_0002);
    check("hitA_instr", fif.ifid_instr, 32'hAAAA_0001);
    check("hitA_pc4",   fif.ifid_pc4, 32'h104);
    check("hitA_valid", {31'b0, fif.ifid_valid}, 32'd1);
    drive(1, 32'h10C, 0, 0, 0, 1, 32'hCCCC_0003);
    check("hitB_instr", fif.ifid_instr, 32'hBBBB_0002);
    check("hitB_pc4",   fif.ifid_pc4, 32'h108);

    // Stall for two cycles with hits returning.
    drive(1, 32'h110, 0, 1, 0, 1, 32'hDDDD_0004);
    check("hitC_instr", fif.ifid_instr, 32'hCCCC_0003);
    check("hitC_pc4",   fif.ifid_pc4, 32'h10C);
    drive(1, 32'h110, 0, 1, 0, 1, 32'hDDDD_0004);
    check("stall_addr",  fif.imemaddr, 32'h10C);
    check("stall_instr", fif.ifid_instr, 32'hCCCC_0003);
    check("stall_valid", {31'b0, fif.ifid_valid}, 32'd1);
    drive(1, 32'h110, 0, 0, 0, 1, 32'hDDDD_0004);
    check("stall2_addr",  fif.imemaddr, 32'h10C);
    check("stall2_instr", fif.ifid_instr, 32'hCCCC_0003);
    drive(1, 32'h200, 0, 0, 0, 1, 32'h1111_2222);
    check("unstall_instr", fif.ifid_instr, 32'hDDDD_0004);
    check("unstall_pc4",   fif.ifid_pc4, 32'h110);

    // Redirect during a miss at 0x200.
    drive(1, 32'h400, 1, 0, 0, 0, 0);
    check("rdm_addr0", fif.imemaddr, 32'h200);
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    check("rdm_state", {30'b0, fif.state}, {30'b0, DRAIN});
    check("rdm_addr1", fif.imemaddr, 32'h200);
    check("rdm_valid", {31'b0, fif.ifid_valid}, 32'd0);
    drive(1, 32'h0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    drive(1, 32'h404, 0, 0, 0, 1, 32'h4444_0000);
    check("rdm_target", fif.imemaddr, 32'h400);
    check("rdm_nolatch", {31'b0, fif.ifid_valid}, 32'd0);

    // Redirect + stall + hit flushes rather than holds.
    drive(1, 32'h80, 1, 1, 0, 1, 32'h5555_0000);
    check("rs_prev_valid", {31'b0, fif.ifid_valid}, 32'd1);
    drive(1, 32'hFFFF_FFFC, 1, 0, 0, 1, 32'h6666_0000);
    check("rs_valid", {31'b0, fif.ifid_valid}, 32'd0);
    check("rs_pc",    fif.imemaddr, 32'h80);

    // PC4 wraps at the top of the address space.
    drive(1, 32'h0, 0, 0, 0, 1, 32'h7777_0000);
    check("wrap_addr", fif.imemaddr, 32'hFFFF_FFFC);
    check("wrap_pc4",  fif.PC4, 32'h0);
    drive(1, 32'h500, 1, 0, 0, 0, 0);
    check("wrap_ifid_pc4", fif.ifid_pc4, 32'h0);

    // Halt while draining, then try to disturb it.
    drive(1, 32'h0, 0, 0, 1, 0, 0);
    check("halt_drain", {30'b0, fif.state}, {30'b0, DRAIN});
    held = 32'h500;
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom(), 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), $urandom());
      check("halt_ren",   {31'b0, fif.imemREN}, 32'd0);
      check("halt_addr",  fif.imemaddr, held);
      check("halt_valid", {31'b0, fif.ifid_valid}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h104, 0, 0, 0, 0, 0);
    check("recover_addr", fif.imemaddr, PC0);
    check("recover_ren",  {31'b0, fif.imemREN}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = !(m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0));
      rd    = ($urandom_range(0, 5) == 0);
      st    = ($urandom_range(0, 3) == 0);
      hl    = ($urandom_range(0, 59) == 0);
      hit   = ($urandom_range(0, 1) == 1);
      npc   = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : m_pc + 32'd4;
      drive(rst_n, npc, rd, st, hl, hit, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the architectural PC register. Each cycle it presents the PC to the instruction cache and returns PC+4 to the next-PC block. It loads the PC from `next_PC` on progress or redirect, and writes the IF/ID latch. It sits between the next-PC logic (upstream of the PC) and decode (downstream of IF/ID). It tracks an outstanding icache miss across a redirect so that the wrong-path word is never latched.

## Interface
Parameters:
- `PC0`, default `32'h0000_0000`: reset PC value.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `next_PC`  in  32  PC selected by the next-PC block.
- `redirect`  in  1  `next_PC` is a taken branch/jump target; the current fetch is wrong-path.
- `stall`  in  1  hazard-unit hold of PC and IF/ID.
- `halt`  in  1  halt decoded downstream; sticky stop of fetch.
- `ihit`  in  1  `imemload` valid for `imemaddr` this cycle.
- `imemload`  in  32  instruction word from icache.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address.
- `PC4`  out  32  PC+4 to the next-PC block.
- `ifid_instr`  out  32  latched instruction.
- `ifid_pc4`  out  32  PC+4 of the latched instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- State register: FETCH, DRAIN, HALTED. Registers: `pc`, `pend_addr`, IF/ID triple.
- Reset (`nRST`=0 at edge) sets `pc`=`PC0`, `pend_addr`=0, state=FETCH, `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0.
- Combinational outputs:
  - `PC4` = `pc`+4, mod 2^32 (`32'hFFFF_FFFC` → 0).
  - `imemREN` = `nRST` and state≠HALTED.
  - `imemaddr` = `pend_addr` in DRAIN, else `pc`.
- FETCH, in priority order:
  - `halt`: go to HALTED, `ifid_valid`←0, `pc` held.
  - `redirect`: `pc`←`next_PC`, `ifid_valid`←0. If `ihit`=0, `pend_addr`←old `pc` and go to DRAIN. If `ihit`=1, discard the word and stay in FETCH.
  - `stall`: hold `pc` and all IF/ID fields, even if `ihit`=1. The word is re-requested next cycle.
  - `ihit`: IF/ID ← {`imemload`, `PC4`, 1}, `pc`←`next_PC`.
  - Otherwise (miss): `ifid_valid`←0, `pc` held.
- DRAIN (waits for the abandoned miss to return; the icache cannot cancel):
  - `halt`: go to HALTED.
  - `redirect`: `pc`←`next_PC`; the latest redirect wins; `pend_addr` unchanged.
  - `ihit`: the returned word is discarded and state goes to FETCH.
  - `ifid_valid` is 0 throughout. `stall` has no effect on draining.
- HALTED is absorbing until reset. `imemREN`=0, and all registers hold, except `ifid_valid`, which stays 0.

## Timing
- Fetch latency: IF/ID is valid on the edge after the first cycle with `ihit`=1, FETCH, and no halt/redirect/stall.
- Throughput: one instruction per cycle on back-to-back hits.
- Redirect penalty: redirect with a hit costs 1 bubble. Redirect during a miss costs the remaining miss cycles + 1 bubble before the target is requested.
- `pc` reaches the target on the edge of the redirect cycle. The target address appears on `imemaddr` in the next cycle that is in FETCH.
- Reset mid-DRAIN drops the pending miss. The cache controller resets on the same `nRST`.
- `stall` and `redirect` asserted together: redirect wins, and IF/ID is flushed, not held.

## Structure
- `word_t` comes from `cpu_types_pkg`. Add `fetch_state_t` (FETCH, DRAIN, HALTED, 2-bit enum) to `cpu_types_pkg`.
- New interface `fetch_if.vh` (include-guarded) with modports `fe` and `tb`, carrying every port above except `CLK`/`nRST`.
- Single module; no sub-module. The PC, FSM and IF/ID live in one `always_ff` with a separate next-state `always_comb`.

## Test plan
- Reset: `PC0`=`32'h0000_0100`, `nRST` low 2 cycles → `imemaddr`=`0x100`, `PC4`=`0x104`, `ifid_valid`=0, `imemREN`=0 while low and 1 after release.
- Hit stream: `ihit`=1, `next_PC`=`PC4` for 3 cycles with words A, B, C → IF/ID shows {A, `0x104`}, {B, `0x108`}, {C, `0x10C`} on successive edges with `ifid_valid`=1.
- Stall: `stall`=1 for 2 cycles with `ihit`=1 → `pc` and IF/ID unchanged. On release, the same address is fetched and latched once.
- Redirect during miss: `pc`=`0x200`, `ihit`=0, `redirect`=1, `next_PC`=`0x400` → DRAIN with `imemaddr`=`0x200`. When `ihit`=1 arrives, the word is not latched. The next cycle `imemaddr`=`0x400`.
- Redirect with hit plus stall: `redirect`=1, `stall`=1, `ihit`=1, `next_PC`=`0x80` → `ifid_valid`=0 and `pc`=`0x80` next cycle.
- Halt: `halt`=1 during DRAIN → HALTED, `imemREN`=0 and held for 10 cycles despite `ihit`/`redirect`. Reset recovers to `PC0`.
